// File: rtl/inst_mem_loader_if.sv
// Byte stream in from the UART receiver and byte-write bus out to the
// instruction memory, grouped so the loader sees one bundle.
interface inst_mem_loader_if #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_SIZE  = 8
);
    logic                 i_rx_done;
    logic [MEM_SIZE-1:0]  i_rx_data;
    logic                 o_write_enable;
    logic [ADDR_SIZE-1:0] o_write_addr;
    logic [MEM_SIZE-1:0]  o_write_data;

    // Loader side: consumes received bytes, drives memory writes.
    modport master (
        input  i_rx_done,
        input  i_rx_data,
        output o_write_enable,
        output o_write_addr,
        output o_write_data
    );

    // Environment side: UART receiver and instruction memory.
    modport slave (
        output i_rx_done,
        output i_rx_data,
        input  o_write_enable,
        input  o_write_addr,
        input  o_write_data
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction-memory program loader.
// Writes received bytes to consecutive addresses from 0, assembles each
// group of 4 bytes big-endian, and stops on an aligned HALT word (DONE)
// or when the memory fills without one (ERROR).
//
// state | meaning
// IDLE  | waiting for i_start after reset
// LOAD  | accepting bytes, one write strobe per received byte
// DONE  | HALT word written; waiting for a new i_start
// ERROR | memory full without HALT; waiting for a new i_start
module inst_mem_loader #(
    parameter int                  ADDR_SIZE = 8,
    parameter int                  MEM_SIZE  = 8,
    parameter int                  MEM_LARGE = 256,
    parameter logic [4*MEM_SIZE-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    inst_mem_loader_if.master    bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [ADDR_SIZE-2:0] o_inst_count
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

    state_t state, state_next;

    // Pointer is one bit wider than the address so it can reach MEM_LARGE.
    logic [ADDR_SIZE:0]       ptr, ptr_next;
    // Only the three most recent bytes must be kept; the fourth is the
    // incoming byte, completing the word in word_shift.
    logic [3*MEM_SIZE-1:0]    word, word_next;
    logic [4*MEM_SIZE-1:0]    word_shift;
    logic [ADDR_SIZE-2:0]     count_next;
    logic                     we_next;
    logic [ADDR_SIZE-1:0]     addr_next;
    logic [MEM_SIZE-1:0]      data_next;

    logic accept;
    logic word_complete;
    logic is_halt;
    logic is_last_addr;

    assign accept        = (state == LOAD) && bus.i_rx_done
                           && (ptr < (ADDR_SIZE+1)'(MEM_LARGE));
    assign word_shift    = {word, bus.i_rx_data};
    assign word_complete = accept && (ptr[1:0] == 2'b11);
    assign is_halt       = (word_shift == HALT_WORD);
    assign is_last_addr  = (ptr[ADDR_SIZE-1:0] == ADDR_SIZE'(MEM_LARGE-1));

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state decision.
    always_comb begin
        state_next = state;
        case (state)
            LOAD: begin
                if (word_complete) begin
                    if (is_halt)           state_next = DONE;
                    else if (is_last_addr) state_next = ERROR;
                end
            end
            default: begin
                if (i_start) state_next = LOAD;
            end
        endcase
    end

    // Next values for the write bus, pointer, assembly word and count.
    always_comb begin
        we_next    = 1'b0;
        addr_next  = bus.o_write_addr;
        data_next  = bus.o_write_data;
        ptr_next   = ptr;
        word_next  = word;
        count_next = o_inst_count;
        if ((state != LOAD) && i_start) begin
            ptr_next   = '0;
            word_next  = '0;
            count_next = '0;
        end
        if (accept) begin
            we_next   = 1'b1;
            addr_next = ptr[ADDR_SIZE-1:0];
            data_next = bus.i_rx_data;
            word_next = word_shift[3*MEM_SIZE-1:0];
            ptr_next  = ptr + (ADDR_SIZE+1)'(1);
            if (word_complete) count_next = o_inst_count + (ADDR_SIZE-1)'(1);
        end
    end

    // Registered outputs; status flags track the state being entered so
    // they change on the same edge as the final byte's strobe.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            bus.o_write_enable <= 1'b0;
            bus.o_write_addr   <= '0;
            bus.o_write_data   <= '0;
            ptr                <= '0;
            word               <= '0;
            o_inst_count       <= '0;
            o_busy             <= 1'b0;
            o_done             <= 1'b0;
            o_error            <= 1'b0;
        end else begin
            bus.o_write_enable <= we_next;
            bus.o_write_addr   <= addr_next;
            bus.o_write_data   <= data_next;
            ptr                <= ptr_next;
            word               <= word_next;
            o_inst_count       <= count_next;
            o_busy             <= (state_next == LOAD);
            o_done             <= (state_next == DONE);
            o_error            <= (state_next == ERROR);
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: the driver queues the expected
// write strobe for each byte it sends; a negedge monitor pops and checks.
module tb_inst_mem_loader;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_start;
    logic       o_busy, o_done, o_error;
    logic [6:0] o_inst_count;

    inst_mem_loader_if #(.ADDR_SIZE(8), .MEM_SIZE(8)) bus_if ();

    inst_mem_loader dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .bus          (bus_if),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_inst_count (o_inst_count)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       done;
        logic       err;
        logic       busy;
        logic [6:0] cnt;
    } exp_t;

    exp_t q[$];
    int   strobe_cyc[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge i_clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge i_clock) begin
        if (bus_if.o_write_enable === 1'b1) begin
            strobe_cyc.push_back(cyc);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got write addr=%0d data=0x%02h, expected no write",
                         bus_if.o_write_addr, bus_if.o_write_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("strobe_addr",  int'(bus_if.o_write_addr), int'(e.addr));
                chk("strobe_data",  int'(bus_if.o_write_data), int'(e.data));
                chk("strobe_done",  int'(o_done),  int'(e.done));
                chk("strobe_error", int'(o_error), int'(e.err));
                chk("strobe_busy",  int'(o_busy),  int'(e.busy));
                chk("strobe_count", int'(o_inst_count), int'(e.cnt));
            end
        end
    end

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input int a, input int c,
                        input logic dn, input logic er);
        exp_t e;
        e.addr = 8'(a);
        e.data = d;
        e.done = dn;
        e.err  = er;
        e.busy = !(dn || er);
        e.cnt  = 7'(c);
        q.push_back(e);
        bus_if.i_rx_done = 1'b1;
        bus_if.i_rx_data = d;
        tick();
        bus_if.i_rx_done = 1'b0;
    endtask

    task automatic stray_byte(input logic [7:0] d);
        bus_if.i_rx_done = 1'b1;
        bus_if.i_rx_data = d;
        tick();
        bus_if.i_rx_done = 1'b0;
        tick();
        tick();
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    int'(bus_if.o_write_enable), 0);
        chk({tag, "_addr"},  int'(bus_if.o_write_addr), 0);
        chk({tag, "_data"},  int'(bus_if.o_write_data), 0);
        chk({tag, "_busy"},  int'(o_busy), 0);
        chk({tag, "_done"},  int'(o_done), 0);
        chk({tag, "_error"}, int'(o_error), 0);
        chk({tag, "_count"}, int'(o_inst_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] normal_bytes [8]  = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] misal_bytes  [12] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00,
                                      8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    initial begin
        i_reset          = 1'b1;
        i_start          = 1'b0;
        bus_if.i_rx_done = 1'b0;
        bus_if.i_rx_data = 8'h00;
        tick();
        tick();
        i_reset = 1'b0;
        chk_all_zero("reset");

        // Ignored inputs: byte in IDLE, start+byte together, start in LOAD.
        stray_byte(8'hA5);
        i_start          = 1'b1;
        bus_if.i_rx_done = 1'b1;
        bus_if.i_rx_data = 8'hEE;
        tick();
        i_start          = 1'b0;
        bus_if.i_rx_done = 1'b0;
        send(8'h11, 0, 0, 1'b0, 1'b0);
        send(8'h22, 1, 0, 1'b0, 1'b0);
        pulse_start();
        send(8'h33, 2, 0, 1'b0, 1'b0);
        drain();
        chk("ignored_busy", int'(o_busy), 1);

        // Normal load ending on an aligned HALT.
        do_reset();
        pulse_start();
        for (int i = 0; i < 8; i++)
            send(normal_bytes[i], i, (i + 1) / 4, i == 7, 1'b0);
        drain();
        chk("normal_done",  int'(o_done), 1);
        chk("normal_busy",  int'(o_busy), 0);
        chk("normal_count", int'(o_inst_count), 2);
        stray_byte(8'h77);

        // Misaligned HALT pattern must not stop the load; restart from DONE.
        pulse_start();
        chk("restart_done",  int'(o_done), 0);
        chk("restart_count", int'(o_inst_count), 0);
        for (int i = 0; i < 12; i++)
            send(misal_bytes[i], i, (i + 1) / 4, i == 11, 1'b0);
        drain();
        chk("misal_done",  int'(o_done), 1);
        chk("misal_count", int'(o_inst_count), 3);

        // Reset mid-load with a byte arriving on the same edge.
        pulse_start();
        for (int i = 0; i < 5; i++)
            send(8'(8'h40 + i), i, (i + 1) / 4, 1'b0, 1'b0);
        i_reset          = 1'b1;
        bus_if.i_rx_done = 1'b1;
        bus_if.i_rx_data = 8'h99;
        tick();
        i_reset          = 1'b0;
        bus_if.i_rx_done = 1'b0;
        chk_all_zero("midreset");
        tick();
        pulse_start();
        send(8'h5A, 0, 0, 1'b0, 1'b0);
        drain();

        // Overflow: fill all 256 bytes with non-HALT data.
        do_reset();
        pulse_start();
        for (int i = 0; i < 256; i++)
            send(8'h00, i, (i + 1) / 4, 1'b0, i == 255);
        drain();
        chk("ovf_error", int'(o_error), 1);
        chk("ovf_done",  int'(o_done), 0);
        chk("ovf_busy",  int'(o_busy), 0);
        chk("ovf_count", int'(o_inst_count), 64);
        stray_byte(8'h12);
        chk("ovf_no_we", int'(bus_if.o_write_enable), 0);

        // Back-to-back bytes, then reload clears status.
        do_reset();
        pulse_start();
        strobe_cyc.delete();
        for (int i = 0; i < 4; i++)
            send(8'hFF, i, (i + 1) / 4, i == 3, 1'b0);
        drain();
        chk("b2b_strobes", strobe_cyc.size(), 4);
        if (strobe_cyc.size() == 4)
            for (int i = 1; i < 4; i++)
                chk("b2b_spacing", strobe_cyc[i] - strobe_cyc[i-1], 1);
        chk("b2b_done", int'(o_done), 1);
        pulse_start();
        chk("reload_done",  int'(o_done), 0);
        chk("reload_count", int'(o_inst_count), 0);
        chk("reload_busy",  int'(o_busy), 1);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
